// File: rtl/queue_reader.sv
// -----------------------------------------------------------------------------
// queue_reader
//   Read-side drain engine for a small synchronous queue. It pulls words out of
//   the queue and presents them on a valid/ready stream. The queue returns data
//   one cycle after the read strobe, so a 2-entry output buffer is kept. Reads
//   are issued only while the buffer plus the in-flight word has room. This
//   sustains one word per cycle and tolerates arbitrary backpressure.
//
// Parameters
//   DATA_W      width of queue words and stream data (default 8)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low (0 = reset)
//   flush       synchronous clear of buffer and in-flight read
//   fifo_empty  queue empty flag
//   fifo_dout   queue read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  queue read strobe (combinational credit check)
//   m_valid     stream data valid
//   m_ready     stream consumer ready
//   m_data      stream data (head of the output buffer)
//   idle        buffer empty, nothing in flight, and queue empty
//   word_count  [only with QUEUE_READER_STATS_EN] count of words handed off;
//               wraps at 16 bits and is not cleared by flush
//
// Build option
//   QUEUE_READER_STATS_EN  adds the word_count output and its counter.
// -----------------------------------------------------------------------------
module queue_reader #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              idle
`ifdef QUEUE_READER_STATS_EN
  ,
  output logic [15:0]       word_count
`endif
);

  // Buffer occupancy doubles as the buffer state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              occ;
  logic              inflight;  // a read was issued last cycle; data arrives now
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;
  logic              push;
  logic              pop;
  logic [2:0]        pending;

  assign m_valid = (occ != EMPTY);
  assign m_data  = head_q;
  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  assign idle    = (occ == EMPTY) & ~inflight & fifo_empty;

  // Credit check: a new read is allowed only if the words already held or on
  // their way, minus the one leaving this cycle, leave room in the buffer.
  // Following m_ready combinationally keeps the stream at one word per cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value before any condition, so no
    // path can leave it unassigned and infer a latch.
    pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd_en = rst & ~flush & ~fifo_empty & (pending < 3'd2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      // The data registers are reset as well because m_data must read 0
      // during reset, not just the valid state.
      occ      <= EMPTY;
      inflight <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else if (flush) begin
      // A returning word is dropped. No read is issued during flush, so
      // nothing returns in the following cycle.
      occ      <= EMPTY;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      unique case (occ)
        EMPTY: begin
          if (push) begin
            head_q <= fifo_dout;
            occ    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= fifo_dout;          // new word goes straight to the head
          end else if (push) begin
            tail_q <= fifo_dout;
            occ    <= TWO;
          end else if (pop) begin
            occ    <= EMPTY;
          end
        end
        TWO: begin
          // Credit keeps push-without-pop from happening here.
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= fifo_dout;
            else      occ    <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

`ifdef QUEUE_READER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     word_count <= 16'd0;
    else if (pop) word_count <= word_count + 16'd1;  // wraps naturally
  end
`endif

endmodule

// File: tb/tb_queue_reader.sv
// -----------------------------------------------------------------------------
// tb_queue_reader
//   Self-checking bench for queue_reader. A behavioural queue (1-cycle read
//   latency) feeds the DUT. Expected words are pushed to a scoreboard when the
//   queue is loaded and are compared as the stream hands them off. A scenario
//   table covers streaming, toggled backpressure and flush. Hand-written
//   sequences cover reset, stall and asynchronous reset mid-drain.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_queue_reader;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       idle;
`ifdef QUEUE_READER_STATS_EN
  logic [15:0] word_count;
`endif

  queue_reader #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .idle       (idle)
`ifdef QUEUE_READER_STATS_EN
    ,
    .word_count (word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scenario table. drop_val is the word the flush discards, or 0 for none.
  typedef struct {
    string    name;
    int       ready_mode;   // 0: always ready, 1: ready on even cycles
    logic [7:0] flush_at;   // flush in the cycle this word is handed off
    logic [7:0] drop_val;
    int       exp_pops;
  } scen_t;

  scen_t scen [3];

  logic [7:0] mq [$];     // queue model contents
  logic [7:0] exp_q [$];  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int viol = 0;
  int rd_count = 0;
  int pops = 0;
  int first_rd = -1;
  int first_pop = -1;
  int last_pop = -1;
  logic rd_s = 1'b0;
  logic flush_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input logic [7:0] drop_val);
    for (int i = 1; i <= 16; i++) begin
      mq.push_back(8'(i));
      if (8'(i) != drop_val) exp_q.push_back(8'(i));
    end
    fifo_empty = 1'b0;
  endtask

  task automatic clear_stats();
    viol = 0; rd_count = 0; pops = 0;
    first_rd = -1; first_pop = -1; last_pop = -1;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick(input logic rdy, input logic [7:0] flush_at);
    m_ready = rdy;
    flush   = 1'b0;
    #1;
    if (flush_at != 8'd0 && m_valid && m_data == flush_at) flush = 1'b1;
    #1;
    if (flush_pending) begin
      check("valid_after_flush", {31'd0, m_valid}, 32'd0);
      flush_pending = 1'b0;
    end
    if (fifo_rd_en && fifo_empty) viol++;
    rd_s = fifo_rd_en;
    if (rd_s) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid && m_ready) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
      if (exp_q.size() == 0) check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
      else                   check("data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
    end
    if (flush) flush_pending = 1'b1;
    @(posedge clk);
    #1;
    if (rd_s && mq.size() > 0) fifo_dout = mq.pop_front();
    fifo_empty = (mq.size() == 0);
    cyc++;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic drain(input int mode, input logic [7:0] flush_at);
    int k = 0;
    while ((exp_q.size() != 0 || !idle) && k < 300) begin
      tick((mode == 0) || (k % 2 == 0), flush_at);
      k++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    scen[0] = '{name: "stream", ready_mode: 0, flush_at: 8'd0, drop_val: 8'd0, exp_pops: 16};
    scen[1] = '{name: "toggle", ready_mode: 1, flush_at: 8'd0, drop_val: 8'd0, exp_pops: 16};
    scen[2] = '{name: "flush",  ready_mode: 0, flush_at: 8'h05, drop_val: 8'h06, exp_pops: 15};

    rst = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_dout = 8'h00;

    // Reset held for two cycles with the queue empty.
    @(negedge clk); @(negedge clk);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
`ifdef QUEUE_READER_STATS_EN
    check("rst_word_count", {16'd0, word_count}, 32'd0);
`endif
    rst = 1'b1;
    tick(1'b1, 8'd0);

    // Table-driven drain scenarios.
    for (int s = 0; s < 3; s++) begin
      clear_stats();
      load(scen[s].drop_val);
      drain(scen[s].ready_mode, scen[s].flush_at);
      check({scen[s].name, "_pops"}, pops, scen[s].exp_pops);
      check({scen[s].name, "_rd_when_empty"}, viol, 0);
      tick(1'b1, 8'd0);
      check({scen[s].name, "_idle"}, {31'd0, idle}, 32'd1);
      if (scen[s].ready_mode == 0 && scen[s].flush_at == 8'd0) begin
        check("first_valid_latency", first_pop - first_rd, 2);
        check("back_to_back", last_pop - first_pop, 15);
      end
    end

    // Full backpressure: only two reads may be issued, head word held.
    clear_stats();
    load(8'd0);
    for (int i = 0; i < 6; i++) tick(1'b0, 8'd0);
    check("stall_reads", rd_count, 2);
    check("stall_valid", {31'd0, m_valid}, 32'd1);
    check("stall_data", {24'd0, m_data}, 32'h01);
    tick(1'b0, 8'd0);
    check("stall_data_hold", {24'd0, m_data}, 32'h01);
    drain(0, 8'd0);
    check("stall_pops", pops, 16);
    check("stall_rd_when_empty", viol, 0);

`ifdef QUEUE_READER_STATS_EN
    check("word_count_before_rst", {16'd0, word_count}, 32'd63);
`endif

    // Asynchronous reset in the middle of a drain.
    clear_stats();
    load(8'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'd0);
    #3 rst = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, m_valid}, 32'd0);
    check("async_rst_data", {24'd0, m_data}, 32'd0);
    check("async_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
`ifdef QUEUE_READER_STATS_EN
    check("async_rst_word_count", {16'd0, word_count}, 32'd0);
`endif
    mq.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    rd_s = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(1'b1, 8'd0);
    check("post_rst_idle", {31'd0, idle}, 32'd1);

    // Restart after reset.
    clear_stats();
    load(8'd0);
    drain(0, 8'd0);
    check("restart_pops", pops, 16);
`ifdef QUEUE_READER_STATS_EN
    check("word_count_16", {16'd0, word_count}, 32'd16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
